// File: rtl/bpug_pkg.sv
// Shared definitions for the BPU group issuer: instruction word layout,
// enable encodings, opcodes and the sequencer state set.
package bpug_pkg;

    localparam int DATA_W     = 8;
    localparam int INSTR_W    = 13;
    localparam int OP_W       = 5;
    localparam int EN_W       = 2;
    localparam int WSEL_W     = 3;
    localparam int HEIGHT_W   = 3;
    localparam int SHIFT_W    = 4;
    localparam int MAX_SHIFTS = 8;

    // Bit offsets of the instruction fields
    localparam int OP_LSB   = 0;
    localparam int DSEL_BIT = 5;
    localparam int EN_LSB   = 6;
    localparam int UP_BIT   = 8;
    localparam int ISEL_BIT = 9;
    localparam int WSEL_LSB = 10;

    localparam logic [EN_W-1:0] EN_NONE = 2'b00;
    localparam logic [EN_W-1:0] EN_WGT  = 2'b01;
    localparam logic [EN_W-1:0] EN_IMG  = 2'b10;

    localparam logic [OP_W-1:0] OP_NOP = 5'd0;

    // Packed instruction word, MSB first so it maps directly onto [12:0]
    typedef struct packed {
        logic [WSEL_W-1:0] wgt_sel;
        logic              img_reg_sel;
        logic              img_reg_up;
        logic [EN_W-1:0]   en;
        logic              data_sel;
        logic [OP_W-1:0]   op;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WGT,
        LOAD_IMG,
        COMPUTE,
        SHIFT,
        DRAIN
    } state_t;

    // The image register only has room for eight shift-up steps
    function automatic logic [SHIFT_W-1:0] sat_shifts(input logic [SHIFT_W-1:0] s);
        return (s > SHIFT_W'(MAX_SHIFTS)) ? SHIFT_W'(MAX_SHIFTS) : s;
    endfunction

endpackage

// File: rtl/bpug_issuer_if.sv
// Upstream byte stream plus the instruction/data bus towards one BPU group.
// The master end is the issuer.
interface bpug_issuer_if;
    import bpug_pkg::*;

    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_ready;
    logic                enable;
    logic                sel;
    logic [INSTR_W-1:0]  instruction_out;
    logic [DATA_W-1:0]   data_out;
    logic [HEIGHT_W-1:0] height;

    modport master (
        input  s_data, s_valid,
        output s_ready, enable, sel, instruction_out, data_out, height
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, enable, sel, instruction_out, data_out, height
    );

endinterface

// File: rtl/bpug_res_pipe.sv
// Delay line that tracks compute beats through the group's result latency.
// The final stage says which beat's result is on the group output now.
module bpug_res_pipe #(
    parameter int RES_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic push_dsel,
    output logic res_valid,
    output logic res_data_sel,
    output logic empty
);

    logic [RES_LAT-1:0] vld_p;
    logic [RES_LAT-1:0] dsel_p;

    // Shift (valid, data_sel) one stage per cycle; data_sel is masked so idle stages stay 0
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            dsel_p <= '0;
        end else begin
            vld_p[0]  <= push_vld;
            dsel_p[0] <= push_dsel & push_vld;
            for (int i = 1; i < RES_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                dsel_p[i] <= dsel_p[i-1];
            end
        end
    end

    assign res_valid    = vld_p[RES_LAT-1];
    assign res_data_sel = dsel_p[RES_LAT-1];
    assign empty        = ~|vld_p;

endmodule

// File: rtl/bpug_issuer.sv
// Sequencer for one BPU group: loads weights and image bytes from the
// upstream stream, then issues compute / shift-up beats per window and
// reports when each group result is valid.
module bpug_issuer
    import bpug_pkg::*;
#(
    parameter int RES_LAT  = 2,
    parameter int N_BPU    = 8,
    parameter int WGT_ROWS = 7,
    parameter int IMG_COLS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_W-1:0]     cfg_op,
    input  logic [SHIFT_W-1:0]  cfg_shifts,
    input  logic [HEIGHT_W-1:0] cfg_height,
    input  logic                cfg_keep_wgt,
    bpug_issuer_if.master       bus,
    output logic                busy,
    output logic                res_valid,
    output logic                res_data_sel,
    output logic                done
);

    localparam int ROW_W = (WGT_ROWS > 1) ? $clog2(WGT_ROWS) : 1;
    localparam int BPU_W = (N_BPU > 1) ? $clog2(N_BPU) : 1;
    localparam int COL_W = $clog2(2 * IMG_COLS);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WGT_ROWS - 1);
    localparam logic [BPU_W-1:0] BPU_LAST = BPU_W'(N_BPU - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * IMG_COLS - 1);

    state_t               state;
    logic [OP_W-1:0]      op_q;
    logic [SHIFT_W-1:0]   shifts_q;
    logic [SHIFT_W-1:0]   win_idx;
    logic [ROW_W-1:0]     row_idx;
    logic [BPU_W-1:0]     bpu_idx;
    logic [COL_W-1:0]     col_idx;
    logic                 phase;

    logic                 enable_q;
    logic                 sel_q;
    logic                 busy_q;
    logic                 done_q;
    instr_t               instr_q;
    logic [DATA_W-1:0]    data_q;
    logic [HEIGHT_W-1:0]  height_q;

    logic                 s_ready_w;
    logic                 hs;
    logic                 accept_start;
    logic                 push_vld;
    logic                 push_dsel;
    logic                 pipe_empty;

    assign s_ready_w    = (state == LOAD_WGT) || (state == LOAD_IMG);
    assign hs           = bus.s_valid && s_ready_w;
    // The IDLE cycle that carries done still belongs to the finished run
    assign accept_start = start && !done_q;

    // A compute beat is any issued beat that neither loads nor shifts
    assign push_vld  = enable_q && (instr_q.en == EN_NONE) && !instr_q.img_reg_up;
    assign push_dsel = instr_q.data_sel;

    assign bus.s_ready         = s_ready_w;
    assign bus.enable          = enable_q;
    assign bus.sel             = sel_q;
    assign bus.instruction_out = instr_q;
    assign bus.data_out        = data_q;
    assign bus.height          = height_q;
    assign busy                = busy_q;
    assign done                = done_q;

    // Latch the compute opcode at run start; it is pure data and needs no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && accept_start) begin
            op_q <= cfg_op;
        end
    end

    // Main sequencer: state, counters and all registered group-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shifts_q <= '0;
            win_idx  <= '0;
            row_idx  <= '0;
            bpu_idx  <= '0;
            col_idx  <= '0;
            phase    <= 1'b0;
            enable_q <= 1'b0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            instr_q  <= '0;
            data_q   <= '0;
            height_q <= '0;
        end else begin
            // Bus idles at zero unless a beat is issued below
            enable_q <= 1'b0;
            instr_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept_start) begin
                        shifts_q <= sat_shifts(cfg_shifts);
                        height_q <= cfg_height;
                        busy_q   <= 1'b1;
                        sel_q    <= 1'b1;
                        win_idx  <= '0;
                        row_idx  <= '0;
                        bpu_idx  <= '0;
                        col_idx  <= '0;
                        phase    <= 1'b0;
                        state    <= cfg_keep_wgt ? LOAD_IMG : LOAD_WGT;
                    end
                end

                LOAD_WGT: begin
                    if (hs) begin
                        enable_q        <= 1'b1;
                        instr_q.en      <= EN_WGT;
                        instr_q.wgt_sel <= WSEL_W'(bpu_idx);
                        data_q          <= bus.s_data;
                        if (row_idx == ROW_LAST) begin
                            row_idx <= '0;
                            if (bpu_idx == BPU_LAST) begin
                                bpu_idx <= '0;
                                state   <= LOAD_IMG;
                            end else begin
                                bpu_idx <= bpu_idx + 1'b1;
                            end
                        end else begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end
                end

                LOAD_IMG: begin
                    if (hs) begin
                        enable_q            <= 1'b1;
                        instr_q.en          <= EN_IMG;
                        instr_q.img_reg_sel <= col_idx[COL_W-1];
                        data_q              <= bus.s_data;
                        if (col_idx == COL_LAST) begin
                            col_idx <= '0;
                            phase   <= 1'b0;
                            state   <= COMPUTE;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                end

                COMPUTE: begin
                    // Two back-to-back beats per window: data_sel 0, then 1
                    enable_q         <= 1'b1;
                    instr_q.op       <= op_q;
                    instr_q.data_sel <= phase;
                    phase            <= ~phase;
                    if (phase) begin
                        state <= (win_idx == shifts_q) ? DRAIN : SHIFT;
                    end
                end

                SHIFT: begin
                    enable_q           <= 1'b1;
                    instr_q.op         <= OP_NOP;
                    instr_q.img_reg_up <= 1'b1;
                    win_idx            <= win_idx + 1'b1;
                    state              <= COMPUTE;
                end

                DRAIN: begin
                    // The last compute beat may still be on the bus this cycle
                    if (pipe_empty && !push_vld) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        sel_q  <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    bpug_res_pipe #(
        .RES_LAT (RES_LAT)
    ) u_res_pipe (
        .clk          (clk),
        .rst          (rst),
        .push_vld     (push_vld),
        .push_dsel    (push_dsel),
        .res_valid    (res_valid),
        .res_data_sel (res_data_sel),
        .empty        (pipe_empty)
    );

endmodule

// File: tb/tb_bpug_issuer.sv
// Randomized bench for bpug_issuer: a stream driver feeds random bytes, a
// recorder logs every beat / result / done, and each scenario compares the
// log against an expected beat list built from the sequencing rules.
module tb_bpug_issuer;
    import bpug_pkg::*;

    localparam int RES_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] cfg_op;
    logic [3:0] cfg_shifts;
    logic [2:0] cfg_height;
    logic       cfg_keep_wgt;
    logic       busy, res_valid, res_data_sel, done;

    bpug_issuer_if bus();

    bpug_issuer #(
        .RES_LAT  (RES_LAT),
        .N_BPU    (8),
        .WGT_ROWS (7),
        .IMG_COLS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_op       (cfg_op),
        .cfg_shifts   (cfg_shifts),
        .cfg_height   (cfg_height),
        .cfg_keep_wgt (cfg_keep_wgt),
        .bus          (bus),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_data_sel (res_data_sel),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Recorder state
    logic [12:0] ob_ins[$];
    logic [7:0]  ob_d[$];
    int          ob_cyc[$];
    int          rv_cyc[$];
    logic        rv_ds[$];
    int          done_cyc[$];
    logic        done_busy;
    logic [2:0]  done_h;
    int          idle_nz, bad_ld, cyc;
    bit          hs_prev;

    // Stimulus bytes and expected beats
    logic [7:0]  stim_q[$];
    logic [12:0] exp_ins[$];
    logic [7:0]  exp_d[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.enable) begin
            ob_ins.push_back(bus.instruction_out);
            ob_d.push_back(bus.data_out);
            ob_cyc.push_back(cyc);
            if (bus.instruction_out[7:6] != 2'b00 && !hs_prev) bad_ld++;
        end else begin
            if (bus.instruction_out != 13'd0 || bus.data_out != 8'd0) idle_nz++;
            if (hs_prev) bad_ld++;
        end
        if (res_valid) begin
            rv_cyc.push_back(cyc);
            rv_ds.push_back(res_data_sel);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            done_busy = busy;
            done_h    = bus.height;
        end
        hs_prev = bus.s_valid && bus.s_ready;
    end

    task automatic clear_rec();
        ob_ins.delete(); ob_d.delete(); ob_cyc.delete();
        rv_cyc.delete(); rv_ds.delete(); done_cyc.delete();
        idle_nz = 0; bad_ld = 0; done_busy = 1'b1; done_h = 3'd0;
    endtask

    // Expected beat list from the loading / windowing rules
    task automatic build_model(input bit keep, input int shifts, input logic [4:0] op);
        int n = (shifts > 8) ? 8 : shifts;
        int off = keep ? 0 : 56;
        logic [12:0] v;
        exp_ins.delete(); exp_d.delete();
        if (!keep) begin
            for (int b = 0; b < 56; b++) begin
                v = (13'(b / 7) << WSEL_LSB) | (13'(EN_WGT) << EN_LSB);
                exp_ins.push_back(v); exp_d.push_back(stim_q[b]);
            end
        end
        for (int c = 0; c < 16; c++) begin
            v = (13'(EN_IMG) << EN_LSB) | (13'(c / 8) << ISEL_BIT);
            exp_ins.push_back(v); exp_d.push_back(stim_q[off + c]);
        end
        for (int w = 0; w <= n; w++) begin
            v = 13'(op) << OP_LSB;
            exp_ins.push_back(v); exp_d.push_back(8'd0);
            exp_ins.push_back(v | (13'd1 << DSEL_BIT)); exp_d.push_back(8'd0);
            if (w < n) begin
                v = (13'd1 << UP_BIT) | (13'(OP_NOP) << OP_LSB);
                exp_ins.push_back(v); exp_d.push_back(8'd0);
            end
        end
    endtask

    // Drive one run: vmode 0 = valid held, 1 = toggling, 2 = random
    task automatic do_run(input bit keep, input int shifts, input logic [4:0] op,
                          input logic [2:0] h, input int vmode, input int abort_at,
                          input int busy_start_at, input bit chain, input bit skip_start,
                          output int timeout);
        int nb = keep ? 16 : 72;
        int idx = 0;
        bit hs;
        stim_q.delete();
        for (int i = 0; i < nb; i++) stim_q.push_back(8'($urandom));
        clear_rec();
        if (!skip_start) begin
            @(posedge clk); #1;
            cfg_op = op; cfg_shifts = 4'(shifts); cfg_height = h; cfg_keep_wgt = keep;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cfg_op = ~op; cfg_height = ~h; cfg_keep_wgt = ~keep; cfg_shifts = 4'($urandom);
        end
        timeout = 1;
        for (int k = 0; k < 3000; k++) begin
            bus.s_valid = (idx < nb) && (vmode == 0 || (vmode == 1 && k % 2 == 0) ||
                                         (vmode == 2 && $urandom_range(1) == 1));
            bus.s_data  = (idx < nb) ? stim_q[idx] : 8'h00;
            start = (k == busy_start_at);
            if (start) begin
                cfg_height = 3'($urandom); cfg_keep_wgt = ~keep; cfg_shifts = 4'($urandom);
            end
            @(negedge clk); #1;
            hs = bus.s_valid && bus.s_ready;
            if (abort_at > 0 && ob_ins.size() == abort_at) begin
                rst = 1'b1; bus.s_valid = 1'b0; start = 1'b0; timeout = 0;
                break;
            end
            if (done_cyc.size() > 0) begin
                bus.s_valid = 1'b0;
                if (chain) begin
                    // start coincident with done: must be ignored
                    start = 1'b1; cfg_height = 3'd2; cfg_keep_wgt = 1'b0;
                    cfg_shifts = 4'd0; cfg_op = 5'd9;
                    @(posedge clk); #1;
                    cfg_height = 3'd5; cfg_keep_wgt = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end else begin
                    start = 1'b0;
                    repeat (6) @(posedge clk);
                    #1;
                end
                timeout = 0;
                break;
            end
            @(posedge clk); #1;
            if (hs) idx++;
        end
        start = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_op = 5'd0; cfg_shifts = 4'd0;
        cfg_height = 3'd0; cfg_keep_wgt = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bus.enable, bus.instruction_out, bus.data_out} !== 22'd0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", {bus.enable, bus.instruction_out, bus.data_out});
        end
        checks++;
        if ({bus.sel, bus.height, bus.s_ready} !== 5'd0) begin
            errors++; $display("FAIL reset_ctl: got %b expected 0", {bus.sel, bus.height, bus.s_ready});
        end
        checks++;
        if ({busy, res_valid, res_data_sel, done} !== 4'd0) begin
            errors++; $display("FAIL reset_status: got %b expected 0000", {busy, res_valid, res_data_sel, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full();
        int to, ne = 0;
        int cc[$];
        do_run(1'b0, 0, 5'd3, 3'd6, 0, 0, -1, 1'b0, 1'b0, to);
        build_model(1'b0, 0, 5'd3);
        checks++; if (to !== 0) begin errors++; $display("FAIL full_timeout: got %0d expected 0", to); end
        checks++;
        if (ob_ins.size() !== exp_ins.size()) begin
            errors++; $display("FAIL full_nbeats: got %0d expected %0d", ob_ins.size(), exp_ins.size());
        end
        for (int i = 0; i < ob_ins.size() && i < exp_ins.size(); i++) begin
            checks++;
            if (ob_ins[i] !== exp_ins[i] || ob_d[i] !== exp_d[i]) begin
                errors++;
                if (ne++ < 4) $display("FAIL full_beat%0d: got %h/%h expected %h/%h", i, ob_ins[i], ob_d[i], exp_ins[i], exp_d[i]);
            end
            if (ob_ins[i][7:6] == 2'b00 && !ob_ins[i][8]) cc.push_back(ob_cyc[i]);
        end
        checks++;
        if (rv_cyc.size() !== 2) begin errors++; $display("FAIL full_nres: got %0d expected 2", rv_cyc.size()); end
        for (int j = 0; j < rv_cyc.size() && j < cc.size(); j++) begin
            checks++;
            if (rv_cyc[j] !== cc[j] + RES_LAT || rv_ds[j] !== 1'(j % 2)) begin
                errors++; $display("FAIL full_res%0d: got cyc %0d ds %0b expected cyc %0d ds %0d", j, rv_cyc[j], rv_ds[j], cc[j] + RES_LAT, j % 2);
            end
        end
        checks++;
        if (done_cyc.size() !== 1) begin errors++; $display("FAIL full_done: got %0d pulses expected 1", done_cyc.size()); end
        checks++;
        if (done_busy !== 1'b0 || done_h !== 3'd6) begin
            errors++; $display("FAIL full_done_state: got busy %0b height %0d expected 0 6", done_busy, done_h);
        end
        checks++;
        if (idle_nz !== 0 || bad_ld !== 0) begin errors++; $display("FAIL full_idle: got %0d/%0d expected 0/0", idle_nz, bad_ld); end
        checks++;
        if (busy !== 1'b0 || bus.sel !== 1'b0 || bus.height !== 3'd6) begin
            errors++; $display("FAIL full_after: got busy %0b sel %0b height %0d expected 0 0 6", busy, bus.sel, bus.height);
        end
    endtask

    task automatic test_backpressure();
        int to, ne = 0;
        do_run(1'b0, 1, 5'($urandom), 3'd1, 1, 0, -1, 1'b0, 1'b0, to);
        build_model(1'b0, 1, cfg_op ^ 5'h1f);
        checks++; if (to !== 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", to); end
        checks++;
        if (ob_ins.size() !== exp_ins.size()) begin
            errors++; $display("FAIL bp_nbeats: got %0d expected %0d", ob_ins.size(), exp_ins.size());
        end
        for (int i = 0; i < ob_ins.size() && i < exp_ins.size(); i++) begin
            checks++;
            if (ob_ins[i] !== exp_ins[i] || ob_d[i] !== exp_d[i]) begin
                errors++;
                if (ne++ < 4) $display("FAIL bp_beat%0d: got %h/%h expected %h/%h", i, ob_ins[i], ob_d[i], exp_ins[i], exp_d[i]);
            end
        end
        checks++;
        if (bad_ld !== 0 || idle_nz !== 0) begin errors++; $display("FAIL bp_stall: got %0d/%0d expected 0/0", bad_ld, idle_nz); end
        checks++;
        if (rv_cyc.size() !== 4 || done_cyc.size() !== 1) begin
            errors++; $display("FAIL bp_res: got %0d res %0d done expected 4 1", rv_cyc.size(), done_cyc.size());
        end
    endtask

    task automatic test_shifts(input int shifts, input int vmode);
        int to, ne = 0, nup = 0, nwgt = 0, ncmp = 0;
        int n = (shifts > 8) ? 8 : shifts;
        logic [4:0] op = 5'($urandom_range(31, 1));
        do_run(1'b1, shifts, op, 3'd3, vmode, 0, -1, 1'b0, 1'b0, to);
        build_model(1'b1, shifts, op);
        checks++; if (to !== 0) begin errors++; $display("FAIL sh%0d_timeout: got %0d expected 0", shifts, to); end
        checks++;
        if (ob_ins.size() !== exp_ins.size()) begin
            errors++; $display("FAIL sh%0d_nbeats: got %0d expected %0d", shifts, ob_ins.size(), exp_ins.size());
        end
        for (int i = 0; i < ob_ins.size() && i < exp_ins.size(); i++) begin
            checks++;
            if (ob_ins[i] !== exp_ins[i] || ob_d[i] !== exp_d[i]) begin
                errors++;
                if (ne++ < 4) $display("FAIL sh%0d_beat%0d: got %h/%h expected %h/%h", shifts, i, ob_ins[i], ob_d[i], exp_ins[i], exp_d[i]);
            end
        end
        foreach (ob_ins[i]) begin
            if (ob_ins[i][8]) nup++;
            if (ob_ins[i][7:6] == 2'b01) nwgt++;
            if (ob_ins[i][7:6] == 2'b00 && !ob_ins[i][8]) ncmp++;
        end
        checks++;
        if (nup !== n || ncmp !== 2 * (n + 1) || nwgt !== 0) begin
            errors++; $display("FAIL sh%0d_counts: got up %0d cmp %0d wgt %0d expected %0d %0d 0", shifts, nup, ncmp, nwgt, n, 2 * (n + 1));
        end
        checks++;
        if (rv_cyc.size() !== 2 * (n + 1) || done_cyc.size() !== 1) begin
            errors++; $display("FAIL sh%0d_res: got %0d res %0d done expected %0d 1", shifts, rv_cyc.size(), done_cyc.size(), 2 * (n + 1));
        end
    endtask

    task automatic test_reset_midrun();
        int to;
        do_run(1'b0, 2, 5'd7, 3'd4, 0, 30, -1, 1'b0, 1'b0, to);
        @(negedge clk); #1;
        checks++;
        if ({bus.enable, bus.instruction_out, bus.data_out, bus.sel, bus.height} !== 26'd0) begin
            errors++; $display("FAIL abort_bus: got %h expected 0", {bus.enable, bus.instruction_out, bus.data_out, bus.sel, bus.height});
        end
        checks++;
        if ({busy, done, res_valid, bus.s_ready} !== 4'd0) begin
            errors++; $display("FAIL abort_status: got %b expected 0000", {busy, done, res_valid, bus.s_ready});
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_cyc.size() !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cyc.size()); end
        do_run(1'b0, 0, 5'd2, 3'd1, 2, 0, -1, 1'b0, 1'b0, to);
        checks++;
        if (to !== 0 || ob_ins.size() !== 74) begin
            errors++; $display("FAIL restart_nbeats: got %0d (timeout %0d) expected 74", ob_ins.size(), to);
        end
        checks++;
        if (ob_ins.size() == 0 || ob_ins[0] !== (13'(EN_WGT) << EN_LSB) || ob_d[0] !== stim_q[0]) begin
            errors++; $display("FAIL restart_first: got %h/%h expected %h/%h", ob_ins.size() ? ob_ins[0] : 13'h1fff, ob_d.size() ? ob_d[0] : 8'hxx, 13'(EN_WGT) << EN_LSB, stim_q[0]);
        end
    endtask

    task automatic test_start_ignored();
        int to, ne = 0;
        do_run(1'b0, 1, 5'd12, 3'd3, 0, 0, 20, 1'b1, 1'b0, to);
        build_model(1'b0, 1, 5'd12);
        checks++; if (to !== 0) begin errors++; $display("FAIL busy_timeout: got %0d expected 0", to); end
        checks++;
        if (ob_ins.size() !== exp_ins.size()) begin
            errors++; $display("FAIL busy_nbeats: got %0d expected %0d", ob_ins.size(), exp_ins.size());
        end
        for (int i = 0; i < ob_ins.size() && i < exp_ins.size(); i++) begin
            checks++;
            if (ob_ins[i] !== exp_ins[i] || ob_d[i] !== exp_d[i]) begin
                errors++;
                if (ne++ < 4) $display("FAIL busy_beat%0d: got %h/%h expected %h/%h", i, ob_ins[i], ob_d[i], exp_ins[i], exp_d[i]);
            end
        end
        checks++;
        if (done_h !== 3'd3) begin errors++; $display("FAIL busy_height: got %0d expected 3", done_h); end
        // Second run was launched by the start one cycle after done
        do_run(1'b1, 0, 5'd9, 3'd5, 2, 0, -1, 1'b0, 1'b1, to);
        build_model(1'b1, 0, 5'd9);
        checks++;
        if (to !== 0 || ob_ins.size() !== exp_ins.size()) begin
            errors++; $display("FAIL chain_nbeats: got %0d (timeout %0d) expected %0d", ob_ins.size(), to, exp_ins.size());
        end
        ne = 0;
        for (int i = 0; i < ob_ins.size() && i < exp_ins.size(); i++) begin
            checks++;
            if (ob_ins[i] !== exp_ins[i] || ob_d[i] !== exp_d[i]) begin
                errors++;
                if (ne++ < 4) $display("FAIL chain_beat%0d: got %h/%h expected %h/%h", i, ob_ins[i], ob_d[i], exp_ins[i], exp_d[i]);
            end
        end
        checks++;
        if (bus.height !== 3'd5 || done_h !== 3'd5 || done_cyc.size() !== 1) begin
            errors++; $display("FAIL chain_height: got %0d/%0d done %0d expected 5/5 1", bus.height, done_h, done_cyc.size());
        end
    endtask

    initial begin
        cyc = 0; hs_prev = 1'b0;
        clear_rec();
        test_reset();
        test_full();
        test_backpressure();
        test_shifts(3, 0);
        test_reset_midrun();
        test_start_ignored();
        test_shifts(15, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
